// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding, source ids and sizing helper for the FIFO write arbiter
package axis_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;
  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;
  function automatic int clog2_beats(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-requester round-robin picker; ties go to the source not served last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = &req ? ~last_served : req[1];
endmodule

// File: rtl/axis_fifo_wr_arbiter.sv
// axis_fifo_wr_arbiter: packet-level round-robin sharing of one FIFO write port between two AXI-Stream sources
module axis_fifo_wr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [WIDTH-1:0] s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_din_last,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic [1:0]       ovl_err
);
  localparam int BW = clog2_beats(MAX_BEATS);
  state_t           r_state;
  logic             r_grant;
  logic             r_last_served;
  logic [BW-1:0]    r_beat_cnt;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;
  logic [1:0]       r_ovl;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_xfer;
  logic             w_rdy;
  logic             w_valid;
  logic             w_last;
  logic             w_forced;
  logic             w_din_last;
  logic             w_wr;
  rr_arb2 u_arb (
    .req        ({s1_tvalid, s0_tvalid}),
    .last_served(r_last_served),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );
  always_comb begin
    w_xfer     = r_state == ST_XFER;
    w_rdy      = w_xfer & ~fifo_full;
    w_valid    = r_grant ? s1_tvalid : s0_tvalid;
    w_last     = r_grant ? s1_tlast : s0_tlast;
    w_forced   = r_beat_cnt == BW'(MAX_BEATS - 1);
    w_din_last = w_xfer & (w_last | w_forced);
    w_wr       = w_rdy & w_valid;
  end
  assign s0_tready     = w_rdy & (r_grant == SRC0);
  assign s1_tready     = w_rdy & (r_grant == SRC1);
  assign fifo_wr_en    = w_wr;
  assign fifo_din      = w_xfer ? (r_grant ? s1_tdata : s0_tdata) : '0;
  assign fifo_din_last = w_din_last;
  assign grant_id      = r_grant;
  assign busy          = w_xfer;
  assign pkt_cnt0      = r_pkt_cnt0;
  assign pkt_cnt1      = r_pkt_cnt1;
  assign ovl_err       = r_ovl;
  // last_served resets to SRC1 so source 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= SRC0;
      r_last_served <= SRC1;
      r_beat_cnt    <= '0;
      r_pkt_cnt0    <= '0;
      r_pkt_cnt1    <= '0;
      r_ovl         <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_gnt_valid) begin
        r_state    <= ST_XFER;
        r_grant    <= w_gnt_id;
        r_beat_cnt <= '0;
      end
    end else if (w_wr) begin
      r_beat_cnt <= r_beat_cnt + BW'(1);
      if (w_din_last) begin
        r_state       <= ST_IDLE;
        r_last_served <= r_grant;
        if (r_grant == SRC1) r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
        else r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
        if (!w_last) r_ovl[r_grant] <= 1'b1;
      end
    end
  end
endmodule
